// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction fetch stage with IF/ID register and one outstanding imem request.
// Optional perf counters (o_fetch_cnt, o_stall_cnt) exist only when RISCV_FETCH_PERF_CNT_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_fetch #(
   parameter logic [`XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_stall_d,
   input  logic              i_flush_d,
   input  logic              i_pc_src_e,
   input  logic [`XLEN-1:0]  i_pc_target_e,
   output logic              o_imem_req,
   output logic [`XLEN-1:0]  o_imem_addr,
   input  logic              i_imem_ready,
   input  logic              i_imem_rvalid,
   input  logic [31:0]       i_imem_rdata,
   output logic [31:0]       o_instr_d,
   output logic [`XLEN-1:0]  o_pc_d,
   output logic [`XLEN-1:0]  o_pc_plus_4d,
   output logic              o_valid_d
`ifdef RISCV_FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       o_fetch_cnt,
   output logic [31:0]       o_stall_cnt
`endif
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] ADDR = 3'd1;
   localparam logic [2:0] WAIT = 3'd2;
   localparam logic [2:0] HOLD = 3'd3;
   localparam logic [2:0] KILL = 3'd4;

   localparam logic [`XLEN-1:0] PC_INC = `XLEN'(4);

   logic [2:0]       state_q, state_d;
   logic [`XLEN-1:0] pc_q, pc_d;
   logic [`XLEN-1:0] req_pc_q, req_pc_d;
   logic [31:0]      pend_q, pend_d;
   logic [31:0]      instr_q, instr_d;
   logic [`XLEN-1:0] pc_id_q, pc_id_d;
   logic [`XLEN-1:0] pc4_id_q, pc4_id_d;
   logic             valid_q, valid_d;
   logic             load;
   logic [31:0]      load_instr;
   logic [`XLEN-1:0] target_aligned;

   assign target_aligned = {i_pc_target_e[`XLEN-1:2], 2'b00};

   // Request is withheld during a redirect so nothing is accepted for a stale PC.
   assign o_imem_req  = (state_q == ADDR) && !i_pc_src_e;
   assign o_imem_addr = pc_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      pend_d     = pend_q;
      instr_d    = instr_q;
      pc_id_d    = pc_id_q;
      pc4_id_d   = pc4_id_q;
      valid_d    = valid_q;
      load       = 1'b0;
      load_instr = i_imem_rdata;

      case (state_q)
         IDLE: state_d = ADDR;
         ADDR: begin
            if (i_imem_ready) begin
               req_pc_d = pc_q;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (i_imem_rvalid) begin
               if (i_stall_d) begin
                  pend_d  = i_imem_rdata;
                  state_d = HOLD;
               end else begin
                  load    = 1'b1;
                  pc_d    = pc_q + PC_INC;
                  state_d = ADDR;
               end
            end
         end
         HOLD: begin
            if (!i_stall_d) begin
               load       = 1'b1;
               load_instr = pend_q;
               pc_d       = pc_q + PC_INC;
               state_d    = ADDR;
            end
         end
         KILL: begin
            if (i_imem_rvalid) state_d = ADDR;
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         instr_d  = load_instr;
         pc_id_d  = req_pc_q;
         pc4_id_d = req_pc_q + PC_INC;
         valid_d  = 1'b1;
      end

      if (i_pc_src_e) begin
         pc_d   = target_aligned;
         pend_d = '0;
      end

      // In KILL a redirect only retargets the PC; the drop of the stale response still pends.
      if (i_pc_src_e && (state_q != KILL)) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         state_d = ((state_q == WAIT) && !i_imem_rvalid) ? KILL : ADDR;
      end else if (i_flush_d) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
         pend_q   <= '0;
         instr_q  <= NOP_INSTR;
         pc_id_q  <= '0;
         pc4_id_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         pend_q   <= pend_d;
         instr_q  <= instr_d;
         pc_id_q  <= pc_id_d;
         pc4_id_q <= pc4_id_d;
         valid_q  <= valid_d;
      end
   end

   assign o_instr_d    = instr_q;
   assign o_pc_d       = pc_id_q;
   assign o_pc_plus_4d = pc4_id_q;
   assign o_valid_d    = valid_q;

`ifdef RISCV_FETCH_PERF_CNT_EN
   logic        fetch_inc;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign fetch_inc = load && !i_pc_src_e && !i_flush_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_inc};
      stall_cnt_d = stall_cnt_q + {31'd0, (state_q == HOLD)};
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_fetch_cnt = fetch_cnt_q;
   assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: self-checking bench for riscv_fetch with a scoreboard-driven memory model.
module tb_riscv_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_stall_d, i_flush_d, i_pc_src_e;
   logic [31:0] i_pc_target_e;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ready, i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic [31:0] o_instr_d, o_pc_d, o_pc_plus_4d;
   logic        o_valid_d;
`ifdef RISCV_FETCH_PERF_CNT_EN
   logic [31:0] o_fetch_cnt, o_stall_cnt;
`endif

   riscv_fetch dut (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .i_stall_d     (i_stall_d),
      .i_flush_d     (i_flush_d),
      .i_pc_src_e    (i_pc_src_e),
      .i_pc_target_e (i_pc_target_e),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ready  (i_imem_ready),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_instr_d     (o_instr_d),
      .o_pc_d        (o_pc_d),
      .o_pc_plus_4d  (o_pc_plus_4d),
      .o_valid_d     (o_valid_d)
`ifdef RISCV_FETCH_PERF_CNT_EN
      ,
      .o_fetch_cnt   (o_fetch_cnt),
      .o_stall_cnt   (o_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   typedef struct packed {
      logic [31:0] target;
      logic [31:0] exp_addr;
   } redir_vec_t;

   sb_t        sb_q[$];
   redir_vec_t vecs[4];
   int         n_chk  = 0;
   int         n_pass = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0003;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle_inputs();
      i_stall_d     = 1'b0;
      i_flush_d     = 1'b0;
      i_pc_src_e    = 1'b0;
      i_pc_target_e = '0;
      i_imem_ready  = 1'b0;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
   endtask

   // Memory answers one cycle after each accept; every load is checked against the queue.
   task automatic run_stream(input int n, input logic [31:0] start_pc, output logic [31:0] end_pc);
      logic [31:0] exp_pc;
      logic [31:0] acc_pc;
      logic        acc, will_load;
      int          got, last;
      sb_t         e;
      exp_pc = start_pc;
      acc_pc = '0;
      acc    = 1'b0;
      got    = 0;
      last   = 0;
      for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
         @(negedge clk);
         idle_inputs();
         i_imem_ready  = 1'b1;
         i_imem_rvalid = acc;
         i_imem_rdata  = acc ? mem_word(acc_pc) : 32'h0;
         #1;
         will_load = acc;
         acc = o_imem_req;
         if (acc) begin
            chk("req_addr", o_imem_addr, exp_pc);
            sb_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
            acc_pc = exp_pc;
            exp_pc = exp_pc + 32'd4;
         end
         @(posedge clk);
         #1;
         if (will_load && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("load_pc", o_pc_d, e.pc);
            chk("load_pc4", o_pc_plus_4d, e.pc + 32'd4);
            chk("load_instr", o_instr_d, e.instr);
            chk("load_valid", {31'd0, o_valid_d}, 32'd1);
            if (got > 0) chk("load_spacing", cyc - last, 2);
            last = cyc;
            got++;
         end
      end
      if (got < n) begin
         n_chk++;
         $display("FAIL stream_timeout: got %0d loads expected %0d", got, n);
      end
      idle_inputs();
      end_pc = exp_pc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pc;
      int          accepts;

      vecs[0] = '{target: 32'h0000_0103, exp_addr: 32'h0000_0100};
      vecs[1] = '{target: 32'h0000_2002, exp_addr: 32'h0000_2000};
      vecs[2] = '{target: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC};
      vecs[3] = '{target: 32'h0000_0007, exp_addr: 32'h0000_0004};

      idle_inputs();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr", o_instr_d, NOP);
      chk("rst_pc_d", o_pc_d, 32'h0);
      chk("rst_pc4", o_pc_plus_4d, 32'h0);
      chk("rst_valid", {31'd0, o_valid_d}, 32'd0);
      chk("rst_req", {31'd0, o_imem_req}, 32'd0);
      chk("rst_addr", o_imem_addr, 32'h0);

      // Back-to-back fetch from reset: 0x0, 0x4, 0x8.
      @(negedge clk);
      rstn = 1'b1;
      run_stream(3, 32'h0, pc);

      // Redirect to 0x4, then a response stalled for three cycles.
      @(negedge clk);
      i_pc_src_e    = 1'b1;
      i_pc_target_e = 32'h4;
      @(posedge clk);
      #1;
      idle_inputs();
      @(negedge clk);
      i_imem_ready = 1'b1;
      #1;
      chk("stall_req", {31'd0, o_imem_req}, 32'd1);
      chk("stall_addr", o_imem_addr, 32'h4);
      @(negedge clk);
      i_imem_ready  = 1'b0;
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = 32'h0050_0093;
      i_stall_d     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("hold_instr", o_instr_d, NOP);
         chk("hold_valid", {31'd0, o_valid_d}, 32'd0);
         @(negedge clk);
         i_imem_rvalid = 1'b0;
         i_stall_d     = (i < 2);
         #1;
         chk("hold_no_req", {31'd0, o_imem_req}, 32'd0);
      end
      @(posedge clk);
      #1;
      chk("unstall_instr", o_instr_d, 32'h0050_0093);
      chk("unstall_pc", o_pc_d, 32'h4);
      chk("unstall_pc4", o_pc_plus_4d, 32'h8);
      chk("unstall_valid", {31'd0, o_valid_d}, 32'd1);
`ifdef RISCV_FETCH_PERF_CNT_EN
      chk("perf_fetch", o_fetch_cnt, 32'd4);
      chk("perf_stall", o_stall_cnt, 32'd3);
`endif
      @(negedge clk);
      #1;
      chk("after_hold_addr", o_imem_addr, 32'h8);

      // Redirect while waiting; the stale response must be dropped.
      i_imem_ready = 1'b1;
      @(negedge clk);
      i_imem_ready  = 1'b0;
      i_pc_src_e    = 1'b1;
      i_pc_target_e = 32'h100;
      @(posedge clk);
      #1;
      chk("redir_valid", {31'd0, o_valid_d}, 32'd0);
      chk("redir_instr", o_instr_d, NOP);
      @(negedge clk);
      idle_inputs();
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = 32'hDEAD_BEEF;
      #1;
      chk("kill_no_req", {31'd0, o_imem_req}, 32'd0);
      @(posedge clk);
      #1;
      chk("stale_instr", o_instr_d, NOP);
      chk("stale_valid", {31'd0, o_valid_d}, 32'd0);

      // Memory not ready for five cycles, then one accept.
      accepts = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         idle_inputs();
         i_imem_ready = (i == 5);
         #1;
         chk("rdy_req", {31'd0, o_imem_req}, 32'd1);
         chk("rdy_addr", o_imem_addr, 32'h100);
         if (o_imem_req && i_imem_ready) accepts++;
      end
      @(negedge clk);
      i_imem_ready  = 1'b1;
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(32'h100);
      #1;
      if (o_imem_req && i_imem_ready) accepts++;
      chk("one_accept", accepts, 1);
      @(posedge clk);
      #1;
      chk("rdy_load_pc", o_pc_d, 32'h100);
      chk("rdy_load_instr", o_instr_d, mem_word(32'h100));
      idle_inputs();

      // Redirect table: alignment and wrap-around of PC+4.
      foreach (vecs[k]) begin
         @(negedge clk);
         idle_inputs();
         i_pc_src_e    = 1'b1;
         i_pc_target_e = vecs[k].target;
         @(posedge clk);
         #1;
         chk("tbl_valid", {31'd0, o_valid_d}, 32'd0);
         idle_inputs();
         run_stream(2, vecs[k].exp_addr, pc);
      end

      // Flush together with stall: bubble loaded, PC and request untouched.
      @(negedge clk);
      i_flush_d = 1'b1;
      i_stall_d = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_instr", o_instr_d, NOP);
      chk("flush_valid", {31'd0, o_valid_d}, 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("flush_req", {31'd0, o_imem_req}, 32'd1);
      chk("flush_addr", o_imem_addr, pc);

      // Asynchronous reset while in HOLD.
      run_stream(1, pc, pc);
      @(negedge clk);
      i_imem_ready = 1'b1;
      @(negedge clk);
      i_imem_ready  = 1'b0;
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = 32'h1234_5678;
      i_stall_d     = 1'b1;
      @(negedge clk);
      i_imem_rvalid = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_instr", o_instr_d, NOP);
      chk("arst_pc_d", o_pc_d, 32'h0);
      chk("arst_pc4", o_pc_plus_4d, 32'h0);
      chk("arst_valid", {31'd0, o_valid_d}, 32'd0);
      chk("arst_req", {31'd0, o_imem_req}, 32'd0);
      chk("arst_addr", o_imem_addr, 32'h0);
`ifdef RISCV_FETCH_PERF_CNT_EN
      chk("arst_fetch_cnt", o_fetch_cnt, 32'd0);
      chk("arst_stall_cnt", o_stall_cnt, 32'd0);
`endif

      // Late response after reset release is ignored.
      @(negedge clk);
      rstn          = 1'b1;
      i_stall_d     = 1'b0;
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = 32'hBAD0_0BAD;
      repeat (2) @(posedge clk);
      #1;
      chk("late_instr", o_instr_d, NOP);
      chk("late_valid", {31'd0, o_valid_d}, 32'd0);
      idle_inputs();
      run_stream(1, 32'h0, pc);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/riscv_fetch.md
RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
- REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
- REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble inserted on flush.
- REQ-003 Port list (name, direction, width, meaning):
  - i_clk  in  1  clock; all state updates on rising edge.
  - i_rstn  in  1  reset; asynchronous, active-low.
  - i_stall_d  in  1  decode stall; IF/ID register holds.
  - i_flush_d  in  1  IF/ID register loads bubble.
  - i_pc_src_e  in  1  redirect request from execute.
  - i_pc_target_e  in  `XLEN  redirect target.
  - o_imem_req  out  1  instruction-memory request valid.
  - o_imem_addr  out  `XLEN  request address, equals current PC.
  - i_imem_ready  in  1  memory accepts request.
  - i_imem_rvalid  in  1  response valid.
  - i_imem_rdata  in  32  response instruction.
  - o_instr_d  out  32  IF/ID instruction.
  - o_pc_d  out  `XLEN  IF/ID PC.
  - o_pc_plus_4d  out  `XLEN  IF/ID PC+4.
  - o_valid_d  out  1  IF/ID holds a real instruction.

Function
- REQ-004 FSM states are IDLE, ADDR, WAIT, HOLD and KILL; reset state is IDLE.
- REQ-005 IDLE goes to ADDR unconditionally on the first clock after reset release.
- REQ-006 ADDR drives o_imem_req=1; on i_imem_ready=1 it latches the request PC and goes to WAIT.
- REQ-007 WAIT, on i_imem_rvalid=1 with i_stall_d=0: load IF/ID with rdata, the latched PC and PC+4; set o_valid_d=1; set PC=PC+4; go to ADDR.
- REQ-008 WAIT, on i_imem_rvalid=1 with i_stall_d=1: store rdata in a one-entry pending buffer; IF/ID is unchanged; go to HOLD.
- REQ-009 HOLD issues no request; when i_stall_d=0 it moves the buffer into IF/ID, sets PC=PC+4 and goes to ADDR.
- REQ-010 Redirect (i_pc_src_e=1) has priority over stall and normal flow:
  - PC is set to i_pc_target_e.
  - IF/ID is loaded with NOP_INSTR and o_valid_d=0.
  - The pending buffer is discarded.
  - WAIT with rvalid=0 goes to KILL; all other states go to ADDR.
- REQ-011 KILL drops the next rvalid response and then goes to ADDR; a redirect while in KILL updates PC only.
- REQ-012 i_flush_d=1 without a redirect loads NOP_INSTR and o_valid_d=0 into IF/ID; PC and FSM state are unaffected.
- REQ-013 Flush overrides i_stall_d.
- REQ-014 At most one request is outstanding; o_imem_req=0 in every state except ADDR.
- REQ-015 o_imem_addr and o_imem_req stay stable while o_imem_req=1 and i_imem_ready=0, unless a redirect occurs.
- REQ-016 PC arithmetic is modulo 2^`XLEN; PC+4 wraps from 32'hFFFF_FFFC to 0.
- REQ-017 The two low bits of i_pc_target_e are forced to 0.
- REQ-018 The request address is presented in the same cycle the FSM enters ADDR (combinational from the PC register).

Reset
- REQ-019 While i_rstn=0, regardless of clock, registers take these values:
  - PC=RESET_PC
  - FSM=IDLE
  - o_instr_d=NOP_INSTR
  - o_pc_d=0
  - o_pc_plus_4d=0
  - o_valid_d=0
  - o_imem_req=0
  - pending buffer empty
- REQ-020 Reset asserted mid-transaction abandons the transaction; a late rvalid after reset release while in IDLE or ADDR is ignored.

Configuration
- REQ-021 Macro RISCV_FETCH_PERF_CNT_EN, when defined:
  - Adds output o_fetch_cnt (32 bits), the count of instructions loaded into IF/ID with o_valid_d=1.
  - Adds output o_stall_cnt (32 bits), the count of cycles spent in HOLD.
  - Both counters reset to 0 and wrap at 2^32.
- REQ-022 When RISCV_FETCH_PERF_CNT_EN is undefined, neither port nor its counter logic exists.

Verification
- REQ-023 Reset release with ready=1 and rvalid one cycle after accept: addresses 0x0, 0x4, 0x8 are requested; o_pc_d=0x0/0x4/0x8 with o_valid_d=1, one instruction per 2 cycles.
- REQ-024 Response 0x00500093 at PC 0x4 while i_stall_d=1 for 3 cycles: IF/ID is unchanged for 3 cycles, no request is issued, then o_instr_d=0x00500093 and o_pc_d=0x4.
- REQ-025 Redirect to 0x100 while in WAIT, followed by a stale rvalid: the stale data never reaches IF/ID, o_valid_d=0, and the next request address is 0x100.
- REQ-026 Redirect to 0x103: the request address is 0x100.
- REQ-027 i_imem_ready held low for 5 cycles: o_imem_addr is stable, o_imem_req=1 throughout, and exactly one accept occurs.
- REQ-028 Async reset asserted mid-HOLD: outputs immediately take their REQ-019 values without a clock edge; with the macro defined, o_fetch_cnt=0.
